// File: rtl/h_pkg.sv
`default_nettype none
// ============================================================================
// Module   : h_pkg
// Brief    : Shared types and defaults for the h_rams state-RAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package h_pkg;

    localparam int H_RAM_DEPTH  = 1024;
    localparam int H_RAM_N_REQ  = 3;
    localparam int H_RAM_DATA_W = 32;

    typedef logic [$clog2(H_RAM_DEPTH)-1:0] ram_addr_t;
    typedef logic [H_RAM_DATA_W-1:0]        ram_data_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } h_ram_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/h_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : h_rr_arb
// Brief    : Combinational round-robin grant with a registered priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module h_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    input  logic         adv
);

    localparam int c_ptr_w = (N > 1) ? $clog2(N) : 1;

    logic [c_ptr_w-1:0] r_ptr;
    logic [c_ptr_w-1:0] w_ptr_nxt;
    logic               w_found;
    int                 w_idx;

    // Search starts at the pointer and wraps; the pointer moves past the winner.
    always_comb begin
        gnt       = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N; k++) begin
            if (!w_found) begin
                w_idx = int'(r_ptr) + k;
                if (w_idx >= N) begin
                    w_idx = w_idx - N;
                end
                if (req[w_idx]) begin
                    w_found    = 1'b1;
                    gnt[w_idx] = 1'b1;
                    w_ptr_nxt  = (w_idx == N - 1) ? '0 : c_ptr_w'(w_idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/h_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : h_ram_ctrl
// Brief    : Clears the shared state RAM after reset, then round-robin shares
//            its single port between N_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module h_ram_ctrl
    import h_pkg::*;
#(
    parameter int N_REQ  = H_RAM_N_REQ,
    parameter int DEPTH  = H_RAM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = H_RAM_DATA_W
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [N_REQ-1:0]          req_vld,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_rdy,
    output logic [N_REQ-1:0]          rsp_vld,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      init_req,
    output logic                      init_done,
    output logic                      ram_en,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    h_ram_ctrl_state_t  r_state;
    h_ram_ctrl_state_t  w_state_nxt;
    logic [ADDR_W-1:0]  r_init_cnt;
    logic [ADDR_W-1:0]  w_init_cnt_nxt;
    logic [N_REQ-1:0]   r_rsp_vld;
    logic [N_REQ-1:0]   w_arb_req;
    logic [N_REQ-1:0]   w_gnt;
    logic               w_arb_en;
    logic               w_adv;

    // A re-init request suppresses arbitration in the cycle it is seen.
    assign w_arb_en  = (r_state == RUN) && !init_req;
    assign w_arb_req = req_vld & {N_REQ{w_arb_en}};
    assign w_adv     = |w_gnt;

    h_rr_arb #(
        .N (N_REQ)
    ) u_arb (
        .clk    (clk),
        .arst_n (arst_n),
        .req    (w_arb_req),
        .gnt    (w_gnt),
        .adv    (w_adv)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        ram_en         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_wdata      = '0;
        if (r_state == INIT) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = r_init_cnt;
            if (r_init_cnt == c_last_addr) begin
                w_state_nxt    = RUN;
                w_init_cnt_nxt = '0;
            end else begin
                w_init_cnt_nxt = r_init_cnt + 1'b1;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_gnt[i]) begin
                    ram_en    = 1'b1;
                    ram_we    = req_we[i];
                    ram_addr  = req_addr[i*ADDR_W +: ADDR_W];
                    ram_wdata = req_wdata[i*DATA_W +: DATA_W];
                end
            end
            if (init_req) begin
                w_state_nxt = INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_rsp_vld  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_rsp_vld  <= w_gnt & ~req_we;
        end
    end

    assign req_rdy   = w_gnt;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_data  = ram_rdata;
    assign init_done = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_h_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_h_ram_ctrl
// Brief    : Scoreboard bench for h_ram_ctrl with a behavioural RAM and model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h_ram_ctrl;

    localparam int N  = 3;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [DW-1:0]   rsp_data;
    logic            init_req = 1'b0;
    logic            init_done;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    h_ram_ctrl #(
        .N_REQ (N),
        .DEPTH (DEPTH),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .req_vld   (req_vld),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rdy   (req_rdy),
        .rsp_vld   (rsp_vld),
        .rsp_data  (rsp_data),
        .init_req  (init_req),
        .init_done (init_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM macro with one-cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    bit            chk_en = 1'b0;
    bit            m_run;
    int            m_cnt;
    int            m_ptr;
    int            m_g;
    logic [AW-1:0] m_a;
    rsp_t          m_rsp;
    rsp_t          mon_rsp;
    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t          rq [$];
    int            grant_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected RAM port activity, grants and read responses.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_run) begin
                check("init_done_low", init_done, 0);
                check("init_rdy", req_rdy, 0);
                check("init_ram_ctl", {ram_en, ram_we}, 2'b11);
                check("init_addr", ram_addr, m_cnt[AW-1:0]);
                check("init_wdata", ram_wdata, 0);
                ref_mem[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) begin
                    m_run = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                check("init_done_high", init_done, 1);
                if (init_req) begin
                    check("init_req_rdy", req_rdy, 0);
                    check("init_req_en", ram_en, 0);
                    m_run = 1'b0;
                end else begin
                    m_g = -1;
                    for (int k = 0; k < N; k++) begin
                        if (m_g < 0 && req_vld[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                    end
                    check("grant", req_rdy, (m_g < 0) ? 0 : (1 << m_g));
                    if (m_g < 0) begin
                        check("idle_en", ram_en, 0);
                    end else begin
                        m_a = req_addr[m_g*AW +: AW];
                        check("ram_en", ram_en, 1);
                        check("ram_we", ram_we, req_we[m_g]);
                        check("ram_addr", ram_addr, m_a);
                        if (req_we[m_g]) begin
                            check("ram_wdata", ram_wdata, req_wdata[m_g*DW +: DW]);
                            ref_mem[m_a] = req_wdata[m_g*DW +: DW];
                        end else begin
                            m_rsp.id   = m_g;
                            m_rsp.data = ref_mem[m_a];
                            m_rsp.due  = cyc + 1;
                            rq.push_back(m_rsp);
                        end
                        grant_log.push_back(m_g);
                        m_ptr = (m_g + 1) % N;
                    end
                end
            end
        end
    end

    // Response monitor: pops the scoreboard when a response is due.
    always @(negedge clk) begin
        if (chk_en) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mon_rsp = rq.pop_front();
                check("rsp_vld", rsp_vld, 1 << mon_rsp.id);
                check("rsp_data", rsp_data, mon_rsp.data);
            end else begin
                check("rsp_idle", rsp_vld, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input int a, input logic [DW-1:0] d);
        req_vld[i]            = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a[AW-1:0];
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        chk_en = 1'b0;
        m_run  = 1'b0;
        m_cnt  = 0;
        m_ptr  = 0;
        rq.delete();
        @(negedge clk);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_init_done", init_done, 0);
        check("rst_rdy", req_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done && n < 40) begin
            tick();
            n++;
        end
        check(name, n, DEPTH);
    endtask

    initial begin
        do_reset();
        wait_init("init_len_reset");

        // All requesters valid: strict rotation expected.
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, $urandom_range(DEPTH - 1), '0);
        repeat (6) tick();
        req_vld = '0;
        check("rr_count", grant_log.size(), 6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) check("rr_order", grant_log[k], k % N);

        // Write then read back through a different requester.
        set_req(1, 1'b1, 1'b1, 5, 32'hDEADBEEF);
        tick();
        req_vld = '0;
        set_req(2, 1'b1, 1'b0, 5, '0);
        tick();
        req_vld = '0;
        tick();

        // Never-written address reads back as cleared.
        set_req(0, 1'b1, 1'b0, 9, '0);
        tick();
        req_vld = '0;
        tick();

        // Randomised traffic.
        repeat (300) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(DEPTH - 1), $urandom);
            tick();
        end
        req_vld = '0;
        tick();

        // Re-init with a read in flight and a pending request held through init.
        set_req(0, 1'b1, 1'b0, $urandom_range(DEPTH - 1), '0);
        tick();
        init_req = 1'b1;
        set_req(0, 1'b1, 1'b0, 3, '0);
        tick();
        init_req = 1'b0;
        grant_log.delete();
        wait_init("init_len_reinit");
        tick();
        req_vld = '0;
        check("pending_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) check("pending_id", grant_log[0], 0);
        tick();

        // Reset in the middle of an init sweep.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (7) tick();
        do_reset();
        wait_init("init_len_midreset");

        set_req(2, 1'b1, 1'b0, 9, '0);
        tick();
        req_vld = '0;
        repeat (3) tick();
        check("scoreboard_empty", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
